// File: rtl/cpu_seq_pkg.sv
// Shared types and default widths for the cpu_run_sequencer slice.
package cpu_seq_pkg;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_ARM_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    DUMP_ADDR,
    DUMP_CAP,
    DUMP_OUT,
    FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    OK      = 2'b01,
    TIMEOUT = 2'b10
  } seq_status_t;

  // Smallest counter width that can reach terminal count n (at least 1 bit).
  function automatic int timer_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_run_timer.sv
// run_timer: clearable, saturating up-counter with a terminal-count flag.
// tc is high in the enabled cycle whose increment brings the count to TERM,
// so a state gated by tc lasts exactly TERM enabled cycles.
module run_timer #(
  parameter int W    = 16,
  parameter int TERM = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] MAX     = '1;
  // A terminal count the counter can never reach simply never fires.
  localparam bit           TERM_OK = (TERM >= 1) && ((W >= 31) || (TERM <= (1 << W)));
  localparam logic [W:0]   TERM_V  = (W+1)'(TERM);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != MAX))
      cnt_d = cnt_q + W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_inc = {1'b0, cnt_q} + (W+1)'(1);
  assign tc      = TERM_OK && en && (cnt_inc == TERM_V);
  assign count   = cnt_q;

endmodule

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: drives one miniMips run - preload data memory, pulse the
// core out of PC reset, wait for done (or time out), then stream a window of
// data memory back to the host.
// Build option SEQ_RUN_COUNTER_EN: when defined, a CNT_W-wide saturating run
// counter feeds cycle_count; when undefined, cycle_count reads 0 and a minimal
// counter only serves the timeout (same timeout behaviour either way).
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int ARM_CYCLES     = DEF_ARM_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              dm_own,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              start,
  input  logic              done,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  input  logic              res_ready,
  output logic              run_done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int ARM_W = timer_w(ARM_CYCLES);
`ifdef SEQ_RUN_COUNTER_EN
  localparam int RUN_W = CNT_W;
`else
  localparam int RUN_W = timer_w(TIMEOUT_CYCLES);
`endif

  seq_state_t        state_q, state_d;
  seq_status_t       status_q, status_d;
  logic [ADDR_W-1:0] load_base_q, load_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] rd_len_q, rd_len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic [ARM_W-1:0]  arm_cnt;
  logic              arm_tc;
  logic [RUN_W-1:0]  run_cnt;
  logic              run_tc;
  logic              unused_arm;

  // ARM hold: counts cycles spent in ARM, cleared everywhere else.
  run_timer #(.W(ARM_W), .TERM(ARM_CYCLES)) u_arm_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ARM),
    .en    (state_q == ARM),
    .count (arm_cnt),
    .tc    (arm_tc)
  );
  assign unused_arm = ^arm_cnt;

  // Run length: cleared while arming, counts in RUN, then holds for FINISH.
  run_timer #(.W(RUN_W), .TERM(TIMEOUT_CYCLES)) u_run_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ARM),
    .en    (state_q == RUN),
    .count (run_cnt),
    .tc    (run_tc)
  );

  // Sequencer next-state and port outputs.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    load_base_d = load_base_q;
    rd_base_d   = rd_base_q;
    rd_len_d    = rd_len_q;
    idx_d       = idx_q;
    res_data_d  = res_data_q;
    req_ready   = 1'b0;
    ld_ready    = 1'b0;
    start       = 1'b1;
    dm_own      = 1'b1;
    dm_we       = 1'b0;
    dm_addr     = rd_base_q + idx_q;
    dm_wdata    = ld_data;
    res_valid   = 1'b0;
    res_last    = 1'b0;
    run_done    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_base_d = load_base;
          rd_base_d   = rd_base;
          rd_len_d    = rd_len;
          idx_d       = '0;
          status_d    = NONE;
          state_d     = req_load ? LOAD : ARM;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        dm_addr  = load_base_q + idx_q;
        if (ld_valid) begin
          // Gate with reset so the reset edge itself never commits a write.
          dm_we = rst_n;
          idx_d = idx_q + ADDR_W'(1);
          if (ld_last) begin
            idx_d   = '0;
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (arm_tc) state_d = RUN;
      end
      RUN: begin
        start  = 1'b0;
        dm_own = 1'b0;
        // done takes priority over a coincident timeout.
        if (done) begin
          status_d = OK;
          state_d  = DUMP_ADDR;
        end else if (run_tc) begin
          status_d = TIMEOUT;
          state_d  = DUMP_ADDR;
        end
      end
      DUMP_ADDR: begin
        state_d = (rd_len_q == '0) ? FINISH : DUMP_CAP;
      end
      DUMP_CAP: begin
        res_data_d = dm_rdata;
        state_d    = DUMP_OUT;
      end
      DUMP_OUT: begin
        res_valid = 1'b1;
        res_last  = (idx_q == rd_len_q - ADDR_W'(1));
        if (res_ready) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = res_last ? FINISH : DUMP_ADDR;
        end
      end
      FINISH: begin
        run_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      status_q    <= NONE;
      load_base_q <= '0;
      rd_base_q   <= '0;
      rd_len_q    <= '0;
      idx_q       <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      load_base_q <= load_base_d;
      rd_base_q   <= rd_base_d;
      rd_len_q    <= rd_len_d;
      idx_q       <= idx_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_data = res_data_q;
  assign status   = status_q;

`ifdef SEQ_RUN_COUNTER_EN
  logic [CNT_W-1:0] cycle_count_q;

  // Snapshot the run length as the sequence completes.
  always_ff @(posedge clk) begin
    if (!rst_n)                cycle_count_q <= '0;
    else if (state_q == FINISH) cycle_count_q <= run_cnt;
  end
  assign cycle_count = cycle_count_q;
`else
  logic unused_run;
  assign unused_run  = ^run_cnt;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Scoreboard bench for cpu_run_sequencer: stimulus pushes expected memory
// writes, result words and run outcomes; a negedge monitor pops and compares.
module tb_cpu_run_sequencer;

  localparam int DW = 8, AW = 8, ARMC = 2, TMO = 20, CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_load = 1'b0;
  logic [AW-1:0] load_base = '0, rd_base = '0, rd_len = '0;
  logic          ld_valid = 1'b0, ld_last = 1'b0, ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          dm_own, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          start, done;
  logic          res_valid, res_last, res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          run_done;
  logic [1:0]    status;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ARM_CYCLES(ARMC),
                      .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .load_base(load_base), .rd_base(rd_base), .rd_len(rd_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .dm_own(dm_own), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .start(start), .done(done), .res_valid(res_valid),
    .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
    .run_done(run_done), .status(status), .cycle_count(cycle_count)
  );

  // ---------------- environment: data memory and core -----------------------
  logic [DW-1:0] mem [256];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      mem_init <= 1'b1;
    end else if (dm_we) mem[dm_addr] <= dm_wdata;
    dm_rdata <= mem[dm_addr];
  end

  int   core_cnt = 0;
  int   done_after = 0;   // 0 = core never halts
  logic force_done = 1'b0;
  always @(posedge clk) core_cnt <= start ? 0 : core_cnt + 1;
  assign done = force_done | (!start && (done_after != 0) && (core_cnt == done_after - 1));

  // ---------------- reference model and scoreboard ---------------------------
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] data; logic last; } res_t;
  typedef struct { int len; logic [1:0] st; logic [15:0] cc; } run_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  run_t run_q[$];
  logic [7:0] ref_mem [256];
  logic [1:0] prev_status = 2'b00;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- res_ready driver ----------------------------------------
  int bp_mode = 0;     // 0 always ready, 1 random, 2 stall word 2 for 5 cycles
  int stall_left = 0;
  int acc_words = 0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode == 1) res_ready = ($urandom_range(0, 2) != 0);
    else if (bp_mode == 2 && res_valid && acc_words == 1 && stall_left > 0) begin
      res_ready = 1'b0;
      stall_left--;
    end else res_ready = 1'b1;
  end

  // ---------------- monitor --------------------------------------------------
  bit prev_start = 1'b1, armed = 1'b0, stall_pend = 1'b0, cc_pend = 1'b0;
  int low_cnt = 0, run_len = 0, lat = 0;
  logic [7:0]  sv_data;
  logic        sv_last;
  logic [15:0] cc_exp;
  wr_t w; res_t rr; run_t ru;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b1; armed = 1'b0; stall_pend = 1'b0; cc_pend = 1'b0; low_cnt = 0;
    end else begin
      if (dm_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", dm_addr, dm_wdata);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", dm_addr, w.addr);
          chk("wr_data", dm_wdata, w.data);
        end
      end
      if (!start) begin
        low_cnt++;
        if (low_cnt == 1) chk("dm_own_in_run", dm_own, 0);
      end
      if (start && !prev_start) begin
        run_len = low_cnt; low_cnt = 0; lat = 0; armed = 1'b1;
      end else if (armed) lat++;
      prev_start = start;
      if (res_valid && armed) begin
        chk("done_to_valid_latency", lat, 2);
        armed = 1'b0;
      end
      if (stall_pend) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, sv_data);
        chk("stall_last", res_last, sv_last);
      end
      stall_pend = res_valid && !res_ready;
      sv_data = res_data; sv_last = res_last;
      if (res_valid && res_ready) begin
        acc_words++;
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: data %0h, no result expected", res_data);
        end else begin
          rr = res_q.pop_front();
          chk("res_data", res_data, rr.data);
          chk("res_last", res_last, rr.last);
        end
      end
      if (cc_pend) begin
        chk("cycle_count", cycle_count, cc_exp);
        chk("run_done_width", run_done, 0);
        cc_pend = 1'b0;
      end
      if (run_done) begin
        if (run_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_run_done: status %0h, no completion expected", status);
        end else begin
          ru = run_q.pop_front();
          chk("status", status, ru.st);
          chk("run_length", run_len, ru.len);
          cc_exp = ru.cc; cc_pend = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus tasks -------------------------------------------
  task automatic send_req(input bit ld, input logic [7:0] lb, input logic [7:0] rb,
                          input logic [7:0] rl);
    int k = 0;
    while (!req_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("req_ready_wait", req_ready, 1);
    chk("status_held", status, prev_status);
    req_valid = 1'b1; req_load = ld; load_base = lb; rd_base = rb; rd_len = rl;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("status_cleared", status, 0);
  endtask

  task automatic do_run(input bit ld, input logic [7:0] lb, input int nw, input bit fixed,
                        input logic [7:0] d0, input logic [7:0] rb, input logic [7:0] rl,
                        input int dafter, input int bp, input bit spur);
    logic [7:0] d, a;
    int k;
    run_t r;
    res_t x;
    done_after = dafter; bp_mode = bp; acc_words = 0; stall_left = 5;
    send_req(ld, lb, rb, rl);
    if (ld) begin
      if (spur) begin
        force_done = 1'b1; @(posedge clk); #1; force_done = 1'b0;
        chk("ld_ready_after_spurious_done", ld_ready, 1);
      end
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) == 0) begin ld_valid = 1'b0; @(posedge clk); #1; end
        d = fixed ? 8'(d0 + i * 8'h11) : 8'($urandom);
        a = 8'(lb + i);
        ld_valid = 1'b1; ld_data = d; ld_last = (i == nw - 1);
        wr_q.push_back('{addr: a, data: d});
        ref_mem[a] = d;
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
      end
    end
    // now in the first ARM cycle: a done here must be ignored
    if (spur) begin force_done = 1'b1; @(posedge clk); #1; force_done = 1'b0; end
    for (int i = 0; i < rl; i++) begin
      a = 8'(rb + i);
      x.data = ref_mem[a]; x.last = (i == rl - 1);
      res_q.push_back(x);
    end
    r.len = (dafter != 0 && dafter <= TMO) ? dafter : TMO;
    r.st  = (dafter != 0 && dafter <= TMO) ? 2'b01 : 2'b10;
`ifdef SEQ_RUN_COUNTER_EN
    r.cc  = 16'(r.len);
`else
    r.cc  = 16'd0;
`endif
    run_q.push_back(r);
    prev_status = r.st;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!run_done && k < 3000);
    chk("run_done_seen", run_done, 1);
    @(posedge clk); #1;
    bp_mode = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_start"}, start, 1);
    chk({tag, "_dm_own"}, dm_own, 1);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_run_done"}, run_done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // ---------------- main sequence --------------------------------------------
  initial begin
    logic [7:0] lb, rb;
    int k;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_checks("por");

    // basic run, then timeout, then address wrap
    do_run(1, 8'h10, 3, 1, 8'hAA, 8'h10, 8'd3, 7, 0, 0);
    do_run(0, 8'h00, 0, 0, 8'h00, 8'h10, 8'd2, 0, 0, 0);
    do_run(1, 8'hFE, 4, 0, 8'h00, 8'hFE, 8'd4, 5, 0, 0);
    // backpressure on word 2, then an empty dump
    do_run(1, 8'h40, 4, 0, 8'h00, 8'h40, 8'd4, 3, 2, 0);
    do_run(0, 8'h00, 0, 0, 8'h00, 8'h40, 8'd0, 4, 0, 0);
    // done coincides with timeout; spurious done during LOAD and ARM
    do_run(1, 8'h80, 2, 0, 8'h00, 8'h80, 8'd2, TMO, 0, 1);

    for (int r = 0; r < 16; r++) begin
      lb = 8'($urandom);
      rb = ($urandom_range(0, 1) != 0) ? 8'(lb + $urandom_range(0, 3)) : 8'($urandom);
      do_run($urandom_range(0, 3) != 0, lb, $urandom_range(1, 6), 0, 8'h00, rb,
             8'($urandom_range(0, 5)), $urandom_range(0, 26), 1, $urandom_range(0, 1));
    end

    // reset while the core is running
    done_after = 0;
    send_req(0, 8'h00, 8'h20, 8'd2);
    k = 0;
    while (start && k < 50) begin @(posedge clk); #1; k++; end
    chk("reached_run", start, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    prev_status = 2'b00;
    reset_checks("rst_run");

    // reset while loading with a word still offered
    send_req(1, 8'h60, 8'h60, 8'd2);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 8'($urandom);
      wr_q.push_back('{addr: 8'(8'h60 + i), data: ld_data});
      ref_mem[8'(8'h60 + i)] = ld_data;
      @(posedge clk); #1;
    end
    ld_data = ~ref_mem[8'h62];
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    reset_checks("rst_load");
    @(posedge clk); #1 ld_valid = 1'b0;
    chk("no_write_after_reset", mem[8'h62], ref_mem[8'h62]);

    // recovery run reading back the partial load
    do_run(0, 8'h00, 0, 0, 8'h00, 8'h60, 8'd3, 9, 1, 0);

    repeat (5) @(posedge clk);
    chk("wr_queue_empty", wr_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    chk("run_queue_empty", run_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
